// File: rtl/sdf_pixel_packer_pkg.sv
// Shared types and helpers for the SDF pixel packer: byte type, packing
// constant and the bytes-per-frame calculation for both row layouts.
package sdf_pkg;

  typedef logic [7:0] byte_t;

  localparam int PIXELS_PER_BYTE = 8;

  function automatic int bytes_per_frame(input int img_w, input int img_h, input bit pad);
    if (pad) return img_h * ((img_w + PIXELS_PER_BYTE - 1) / PIXELS_PER_BYTE);
    return (img_w * img_h + PIXELS_PER_BYTE - 1) / PIXELS_PER_BYTE;
  endfunction

endpackage

// File: rtl/sdf_pixel_packer_if.sv
// Pixel-in / byte-out handshake bundle for sdf_pixel_packer.
// master = pixel producer and byte consumer, slave = the packer.
interface sdf_pixel_packer_if #(
  parameter int WIDTH = 16
);
  import sdf_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  byte_t            out_data;
  logic             out_last;
  logic             frame_done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, frame_done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, frame_done
  );

endinterface

// File: rtl/sdf_raster_counter.sv
// Column/row raster position for the packer; advances once per accepted
// pixel and wraps to (0,0) after the last pixel of the frame.
module sdf_raster_counter #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic advance_i,
  output logic row_end_o,
  output logic frame_end_o
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  assign row_end_o   = (col_q == COL_MAX);
  assign frame_end_o = row_end_o && (row_q == ROW_MAX);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (advance_i) begin
      if (row_end_o) begin
        col_d = '0;
        row_d = frame_end_o ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/sdf_pixel_packer.sv
// Thresholds signed SDF samples on their sign and packs them MSB-first into bytes.
// SDF_PACKER_ROW_PAD_EN: start every row on a byte boundary (PBM P4 layout).
module sdf_pixel_packer #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8,
  parameter int IMG_W     = 256,
  parameter int IMG_H     = 256
) (
  input logic               clk,
  input logic               rst,
  sdf_pixel_packer_if.slave bus
);
  import sdf_pkg::*;

  localparam int INT_BITS = WIDTH - FRAC_BITS;
  localparam int SIGN_BIT = INT_BITS + FRAC_BITS - 1;

  logic [2:0] bit_cnt_q, bit_cnt_d;
  byte_t      acc_q, acc_d;
  byte_t      out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;
  logic       frame_done_q, frame_done_d;
  byte_t      byte_w;
  logic       row_end, frame_end, completes, in_hs, out_hs, pix_bit;

  sdf_raster_counter #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_raster (
    .clk        (clk),
    .rst        (rst),
    .advance_i  (in_hs),
    .row_end_o  (row_end),
    .frame_end_o(frame_end)
  );

`ifdef SDF_PACKER_ROW_PAD_EN
  assign completes = (bit_cnt_q == 3'd7) || frame_end || row_end;
`else
  assign completes = (bit_cnt_q == 3'd7) || frame_end;
`endif

  // Only a byte-closing pixel needs the output register free.
  assign bus.in_ready = !(out_valid_q && !bus.out_ready && completes);
  assign in_hs        = bus.in_valid && bus.in_ready;
  assign out_hs       = out_valid_q && bus.out_ready;
  assign pix_bit      = bus.in_data[SIGN_BIT];

  always_comb begin
    byte_w = acc_q;
    byte_w[3'd7 - bit_cnt_q] = pix_bit;
  end

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    acc_d        = acc_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q;
    frame_done_d = out_hs && out_last_q;
    if (out_hs) out_valid_d = 1'b0;
    if (in_hs) begin
      if (completes) begin
        out_data_d  = byte_w;
        out_last_d  = frame_end;
        out_valid_d = 1'b1;
        acc_d       = '0;
        bit_cnt_d   = '0;
      end else begin
        acc_d     = byte_w;
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q    <= '0;
      acc_q        <= '0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      acc_q        <= acc_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sdf_pixel_packer.sv
// Directed bench for sdf_pixel_packer on a 10x2 image; expected bytes depend on
// whether SDF_PACKER_ROW_PAD_EN is defined for the build.
module tb_sdf_pixel_packer;
  import sdf_pkg::*;

  localparam int IW = 10;
  localparam int IH = 2;
`ifdef SDF_PACKER_ROW_PAD_EN
  localparam bit PAD  = 1'b1;
  localparam int NB   = 4;
  localparam int NACC = 1;
`else
  localparam bit PAD  = 1'b0;
  localparam int NB   = 3;
  localparam int NACC = 7;
`endif

  logic clk = 1'b0;
  logic rst;

  sdf_pixel_packer_if #(.WIDTH(16)) bus ();

  sdf_pixel_packer #(
    .WIDTH(16), .FRAC_BITS(8), .IMG_W(IW), .IMG_H(IH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0]  mq_data[$];
  logic        mq_last[$];
  logic [7:0]  eq[$];
  logic [15:0] pat[20];
  int          fd_cnt = 0;
  int          fd_bad = 0;
  int          cyc    = 0;
  logic        last_hs_prev = 1'b0;

  // Byte monitor: samples 1ns after the falling edge, i.e. the values the
  // next rising edge will act on.
  always @(negedge clk) begin
    #1;
    cyc++;
    if (bus.frame_done) begin
      fd_cnt++;
      if (!last_hs_prev) fd_bad++;
    end
    last_hs_prev = bus.out_valid && bus.out_ready && bus.out_last && !rst;
    if (bus.out_valid && bus.out_ready && !rst) begin
      mq_data.push_back(bus.out_data);
      mq_last.push_back(bus.out_last);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called on a falling edge; returns on the falling edge after the handshake.
  task automatic send(input logic [15:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_total++;
      $error("FAIL send_timeout observed=in_ready_low expected=accept_within_50");
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic clear_mon();
    mq_data.delete();
    mq_last.delete();
    fd_cnt = 0;
  endtask

  task automatic check_frames(input string tag, input int frames);
    int idx;
    chk({tag, "_nbytes"}, mq_data.size(), frames * NB);
    for (int f = 0; f < frames; f++) begin
      for (int i = 0; i < NB; i++) begin
        idx = f * NB + i;
        if (idx < mq_data.size()) begin
          chk($sformatf("%s_byte%0d", tag, idx), mq_data[idx], eq[i]);
          chk($sformatf("%s_last%0d", tag, idx), mq_last[idx], (i == NB - 1));
        end
      end
    end
    chk({tag, "_frame_done"}, fd_cnt, frames);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int c0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) pat[i] = (i % 2 == 0) ? 16'h0100 : 16'hFF00;
    pat[8] = 16'h0000;
    pat[9] = 16'h8000;
    for (int i = 10; i < 20; i++) pat[i] = 16'hFF00;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 8'h00);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("bytes_per_frame", bytes_per_frame(IW, IH, PAD), NB);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", bus.in_ready, 1);

    // Solid frame of -1.0
`ifdef SDF_PACKER_ROW_PAD_EN
    eq = '{8'hFF, 8'hC0, 8'hFF, 8'hC0};
`else
    eq = '{8'hFF, 8'hFF, 8'hF0};
`endif
    clear_mon();
    repeat (20) send(16'hFF00);
    repeat (3) @(negedge clk);
    check_frames("solid", 1);

    // Mixed signs: +1.0/-1.0 alternating, then 0 and most-negative
`ifdef SDF_PACKER_ROW_PAD_EN
    eq = '{8'h55, 8'h40, 8'hFF, 8'hC0};
`else
    eq = '{8'h55, 8'h7F, 8'hF0};
`endif
    clear_mon();
    for (int i = 0; i < 20; i++) send(pat[i]);
    repeat (3) @(negedge clk);
    check_frames("mixed", 1);

    // Backpressure on the first byte of a solid frame
`ifdef SDF_PACKER_ROW_PAD_EN
    eq = '{8'hFF, 8'hC0, 8'hFF, 8'hC0};
`else
    eq = '{8'hFF, 8'hFF, 8'hF0};
`endif
    clear_mon();
    repeat (8) send(16'hFF00);
    bus.out_ready = 1'b0;
    chk("bp_first_valid", bus.out_valid, 1);
    for (int k = 0; k < NACC; k++) begin
      chk($sformatf("bp_accept%0d", k), bus.in_ready, 1);
      send(16'hFF00);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFF00;
    repeat (3) @(negedge clk);
    chk("bp_stall_in_ready", bus.in_ready, 0);
    chk("bp_hold_data", bus.out_data, 8'hFF);
    chk("bp_hold_valid", bus.out_valid, 1);
    chk("bp_hold_last", bus.out_last, 0);
    bus.out_ready = 1'b1;
    for (int k = 8 + NACC; k < 20; k++) send(16'hFF00);
    repeat (3) @(negedge clk);
    check_frames("bp", 1);

    // Reset mid-frame, then a full mixed frame
    clear_mon();
    repeat (13) send(16'hFF00);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_data", bus.out_data, 8'h00);
    chk("midrst_out_last", bus.out_last, 0);
    chk("midrst_frame_done", bus.frame_done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`ifdef SDF_PACKER_ROW_PAD_EN
    eq = '{8'h55, 8'h40, 8'hFF, 8'hC0};
`else
    eq = '{8'h55, 8'h7F, 8'hF0};
`endif
    clear_mon();
    for (int i = 0; i < 20; i++) send(pat[i]);
    repeat (3) @(negedge clk);
    check_frames("postrst", 1);

    // Two back-to-back solid frames at full rate
`ifdef SDF_PACKER_ROW_PAD_EN
    eq = '{8'hFF, 8'hC0, 8'hFF, 8'hC0};
`else
    eq = '{8'hFF, 8'hFF, 8'hF0};
`endif
    clear_mon();
    c0 = cyc;
    repeat (40) send(16'hFF00);
    chk("b2b_cycles", cyc - c0, 40);
    repeat (3) @(negedge clk);
    check_frames("b2b", 2);
    chk("frame_done_timing", fd_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sdf_pixel_packer.md
# sdf_pixel_packer

Consumer at the output end of the fixed-point evaluation datapath. It accepts one signed fixed-point result per pixel in raster order and thresholds each result on its sign. It packs the resulting bits MSB-first into bytes and emits a byte stream with a frame-end marker, in the layout the image writer/DMA expects.

## Interface
- WIDTH, 16, total width of the fixed-point input value
- FRAC_BITS, 8, fractional bits of the input; does not affect the threshold, carried for format consistency
- IMG_W, 256, pixels per row, ≥1
- IMG_H, 256, rows per frame, ≥1

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data holds a valid pixel value
- in_ready  output  1  packer accepts in_data this cycle
- in_data  input  WIDTH  signed fixed-point evaluation result
- out_valid  output  1  out_data holds a packed byte
- out_ready  input  1  downstream accepts out_data
- out_data  output  8  packed pixels, first pixel in bit 7
- out_last  output  1  qualifies out_data: this byte holds the frame's final pixel
- frame_done  output  1  one-cycle pulse when the out_last byte handshakes

## Operation
- Input handshake: in_valid && in_ready. Output handshake: out_valid && out_ready.
- Pixel bit = 1 when $signed(in_data) < 0, i.e. inside the shape. A zero or positive value gives 0.
- Each accepted bit shifts into an 8-bit accumulator at position 7-bit_cnt.
- Raster counters: col 0..IMG_W-1, row 0..IMG_H-1, bit_cnt 0..7. All advance only on an input handshake.
- "completes" means the accepted pixel closes a byte. It is true when any of these holds:
  - bit_cnt==7
  - frame end: col==IMG_W-1 && row==IMG_H-1
  - row end, pad build only: col==IMG_W-1
- On a completing handshake:
  - Accumulator plus the new bit loads into the output register; unused low bits are 0.
  - out_valid is set.
  - out_last is set if at frame end.
  - bit_cnt returns to 0 and the accumulator clears.
- Frame end wraps col/row to 0, so the next pixel starts a new frame with no gap or idle state.
- Output register is one entry; out_valid clears on its handshake unless reloaded in the same cycle.
- in_ready = !(out_valid && !out_ready && completes). Non-completing pixels are accepted even while the output byte is stalled.
- Bytes per frame:
  - pad build: IMG_H*ceil(IMG_W/8)
  - no-pad build: ceil(IMG_W*IMG_H/8)

## Timing
- Reset values: out_valid=0, out_data=0x00, out_last=0, frame_done=0, all counters and the accumulator 0. in_ready=1 once out of reset.
- Latency: a byte appears on out_data the cycle after the handshake of its completing pixel.
- Throughput: one pixel per cycle while out_ready=1.
- A simultaneous output handshake and completing input in the same cycle reloads the register. out_valid stays 1 with no bubble.
- out_data and out_last are held stable while out_valid && !out_ready.
- frame_done asserts the cycle after the out_last handshake, for exactly one cycle.
- Reset mid-frame discards the partial byte and any pending output byte. The next pixel is pixel 0 of a new frame.
- in_ready is combinational from state and out_ready. There is no combinational path from in_valid to in_ready.

## Configuration
- SDF_PACKER_ROW_PAD_EN defined: every row starts on a byte boundary. Each row's final byte is padded with zero bits (PBM P4 layout).
- Not defined: bits pack continuously across row boundaries. Only the frame's final byte is zero-padded.

## Structure
- Shared package sdf_pkg holds:
  - typedef byte_t (logic [7:0])
  - constant PIXELS_PER_BYTE=8
  - a function returning bytes per frame from IMG_W, IMG_H and the pad setting
- Sub-module sdf_raster_counter: col/row counters with advance input and row_end/frame_end flags, wrapping at frame end. The packer instantiates it once.

## Test plan
All tests use WIDTH=16, FRAC_BITS=8, IMG_W=10, IMG_H=2, out_ready=1 unless stated.
- Pad build, 20 pixels of 16'hFF00 (-1.0) → bytes FF, C0, FF, C0; out_last only on the 4th; frame_done pulses once.
- No-pad build, same stimulus → bytes FF, FF, F0; out_last on the 3rd.
- Pad build, 8 pixels alternating 16'h0100, 16'hFF00 → first byte 0x55. A pixel of 16'h0000 yields bit 0, 16'h8000 yields bit 1.
- Backpressure: out_ready held low after the first byte → 7 further pixels accepted. The 8th sees in_ready=0 and out_data stays FF. Raising out_ready resumes with no lost or duplicated pixel.
- Reset asserted after 13 accepted pixels → all outputs at reset values. The next 20 pixels produce a complete, correct frame.
- 40 back-to-back pixels of 16'hFF00, pad build → 8 bytes with no bubbles; out_last and frame_done on bytes 4 and 8.
